// File: rtl/mips_pkg.sv
// Shared constants for the writeback path: load size encodings and default datapath widths.
package mips_pkg;

  localparam int DEF_ADDR_SIZE = 5;
  localparam int DEF_WORD_SIZE = 32;

  localparam logic [1:0] LS_BYTE = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_WORD = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth and a separate occupancy counter.
module sync_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DEF_ADDR_SIZE + DEF_WORD_SIZE
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Requests against a full or empty FIFO are ignored rather than corrupting state.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register file write-port arbiter: ALU results take priority, load responses are
// formatted, buffered, and tracked in a per-register busy scoreboard.
module writeback_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      alu_en_i,
  input  logic [ADDR_SIZE-1:0]      alu_rd_i,
  input  logic [WORD_SIZE-1:0]      alu_data_i,
  input  logic                      ld_issue_i,
  input  logic [ADDR_SIZE-1:0]      ld_issue_rd_i,
  // Load response handshake: a beat transfers on a cycle where ld_valid_i and
  // ld_ready_o are both high; ld_ready_o never looks at ld_valid_i.
  input  logic                      ld_valid_i,
  output logic                      ld_ready_o,
  input  logic [ADDR_SIZE-1:0]      ld_rd_i,
  input  logic [WORD_SIZE-1:0]      ld_data_i,
  input  logic [1:0]                ld_size_i,
  input  logic                      ld_signed_i,
  input  logic [1:0]                ld_offset_i,
  output logic                      rd_en_o,
  output logic [ADDR_SIZE-1:0]      rd_o,
  output logic [WORD_SIZE-1:0]      rd_data_o,
  output logic [2**ADDR_SIZE-1:0]   busy_o
);

  localparam int FW   = ADDR_SIZE + WORD_SIZE;
  localparam int NREG = 2**ADDR_SIZE;

  logic [7:0]           byte_lane;
  logic [15:0]          half_lane;
  logic [WORD_SIZE-1:0] fmt_data;

  logic                 fifo_full, fifo_empty;
  logic [FW-1:0]        fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                 accept, use_fifo, bypass, push;

  logic                 sel_valid, sel_is_load;
  logic [ADDR_SIZE-1:0] sel_rd;
  logic [WORD_SIZE-1:0] sel_data;

  logic                 rd_en_q, rd_en_d;
  logic [ADDR_SIZE-1:0] rd_q, rd_d;
  logic [WORD_SIZE-1:0] rd_data_q, rd_data_d;
  logic [NREG-1:0]      busy_q, busy_d;

  // Big-endian lane selection: offset 0 addresses the most significant byte.
  always_comb begin
    byte_lane = 8'h00;
    case (ld_offset_i)
      2'd0:    byte_lane = ld_data_i[WORD_SIZE-1  -: 8];
      2'd1:    byte_lane = ld_data_i[WORD_SIZE-9  -: 8];
      2'd2:    byte_lane = ld_data_i[WORD_SIZE-17 -: 8];
      default: byte_lane = ld_data_i[WORD_SIZE-25 -: 8];
    endcase
    half_lane = ld_offset_i[1] ? ld_data_i[WORD_SIZE-17 -: 16]
                               : ld_data_i[WORD_SIZE-1  -: 16];
    case (ld_size_i)
      LS_BYTE: fmt_data = {{(WORD_SIZE-8){ld_signed_i & byte_lane[7]}}, byte_lane};
      LS_HALF: fmt_data = {{(WORD_SIZE-16){ld_signed_i & half_lane[15]}}, half_lane};
      default: fmt_data = ld_data_i;
    endcase
  end

  assign ld_ready_o = !fifo_full;
  assign accept     = ld_valid_i && ld_ready_o;
  assign use_fifo   = !alu_en_i && !fifo_empty;
  assign bypass     = !alu_en_i && fifo_empty && accept;
  assign push       = accept && !bypass;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (use_fifo),
    .data_i  ({ld_rd_i, fmt_data}),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    sel_valid   = 1'b0;
    sel_is_load = 1'b0;
    sel_rd      = '0;
    sel_data    = '0;
    if (alu_en_i) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd_i;
      sel_data  = alu_data_i;
    end else if (use_fifo) begin
      sel_valid   = 1'b1;
      sel_is_load = 1'b1;
      sel_rd      = fifo_head[FW-1 -: ADDR_SIZE];
      sel_data    = fifo_head[WORD_SIZE-1:0];
    end else if (bypass) begin
      sel_valid   = 1'b1;
      sel_is_load = 1'b1;
      sel_rd      = ld_rd_i;
      sel_data    = fmt_data;
    end
  end

  // Writes to r0 still consume their source but never assert the write enable.
  always_comb begin
    rd_en_d   = sel_valid && (sel_rd != '0);
    rd_d      = sel_valid ? sel_rd   : rd_q;
    rd_data_d = sel_valid ? sel_data : rd_data_q;
  end

  // Clear first, then set, so a same-cycle issue to the retiring register wins.
  always_comb begin
    busy_d = busy_q;
    if (sel_is_load) busy_d[sel_rd] = 1'b0;
    if (ld_issue_i && (ld_issue_rd_i != '0)) busy_d[ld_issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_en_q   <= 1'b0;
      rd_q      <= '0;
      rd_data_q <= '0;
      busy_q    <= '0;
    end else begin
      rd_en_q   <= rd_en_d;
      rd_q      <= rd_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
    end
  end

  assign rd_en_o   = rd_en_q;
  assign rd_o      = rd_q;
  assign rd_data_o = rd_data_q;
  assign busy_o    = busy_q;

endmodule
